// File: rtl/lsu_ctrl.sv
// Load/store unit: turns one core load/store into one or two byte-lane-aligned
// beats on a word-wide req/ack data bus and returns extended load data.
module lsu_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_i,
    input  logic        mem_wren_i,
    input  logic [2:0]  width_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] st_data_i,
    output logic        stall_o,
    output logic        done_o,
    output logic        err_o,
    output logic [31:0] ld_data_o,
    output logic        bus_req_o,
    output logic        bus_we_o,
    output logic [31:0] bus_addr_o,
    output logic [3:0]  bus_be_o,
    output logic [31:0] bus_wdata_o,
    input  logic        bus_ack_i,
    input  logic [31:0] bus_rdata_i
);

    typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, DONE} state_e;

    typedef struct packed {
        logic        we;
        logic [2:0]  width;
        logic [31:0] addr;
        logic [31:0] data;
    } lsu_req_t;

    // Counter only ever holds 0..TIMEOUT_CYCLES-1.
    localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] TO_LAST = CW'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

    state_e        state_q, state_d;
    lsu_req_t      req_q, req_d, cur;
    logic [31:0]   rdata0_q, rdata0_d, rdata1_q, rdata1_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          bus_req_q, bus_req_d, bus_we_q, bus_we_d;
    logic [31:0]   bus_addr_q, bus_addr_d, bus_wdata_q, bus_wdata_d;
    logic [3:0]    bus_be_q, bus_be_d;
    logic          err_q, err_d;
    logic [31:0]   ld_data_q, ld_data_d;

    logic          legal, split, in_beat, timeout_hit, fail;
    logic [3:0]    size_mask;
    logic [1:0]    off;
    logic [7:0]    be_wide;
    logic [63:0]   wdata_wide, wdata_lane;
    logic [31:0]   raw, ld_ext, base_addr;

    // Request decode: while idle look at the live inputs, afterwards at the latched copy,
    // so the registered bus outputs are identical in the accept cycle and during the beat.
    always_comb begin
        if (state_q == IDLE) begin
            cur.we    = mem_wren_i;
            cur.width = width_i;
            cur.addr  = addr_i;
            cur.data  = st_data_i;
        end else begin
            cur = req_q;
        end

        legal     = 1'b1;
        size_mask = 4'b0001;
        case (cur.width)
            3'b000, 3'b100:         size_mask = 4'b0001;
            3'b001, 3'b010, 3'b110: size_mask = 4'b0011;
            3'b111:                 size_mask = 4'b1111;
            default:                legal     = 1'b0;
        endcase

        off        = cur.addr[1:0];
        base_addr  = {cur.addr[31:2], 2'b00};
        be_wide    = {4'b0000, size_mask} << off;
        split      = |be_wide[7:4];
        wdata_wide = {32'h0, cur.data} << {off, 3'b000};
        for (int b = 0; b < 8; b++)
            wdata_lane[8*b +: 8] = be_wide[b] ? wdata_wide[8*b +: 8] : 8'h00;
    end

    always_comb begin
        state_d  = state_q;
        req_d    = req_q;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;
        fail     = 1'b0;
        in_beat  = (state_q == BEAT0) || (state_q == BEAT1);
        timeout_hit = (TIMEOUT_CYCLES != 0) && in_beat && !bus_ack_i && (cnt_q == TO_LAST);

        case (state_q)
            IDLE: begin
                if (req_i) begin
                    if (legal) begin
                        state_d  = BEAT0;
                        req_d    = cur;
                        rdata0_d = '0;
                        rdata1_d = '0;
                    end else begin
                        state_d = DONE;
                        fail    = 1'b1;
                    end
                end
            end
            BEAT0: begin
                if (bus_ack_i) begin
                    rdata0_d = bus_rdata_i;
                    state_d  = split ? BEAT1 : DONE;
                end else if (timeout_hit) begin
                    state_d = DONE;
                    fail    = 1'b1;
                end
            end
            BEAT1: begin
                if (bus_ack_i) begin
                    rdata1_d = bus_rdata_i;
                    state_d  = DONE;
                end else if (timeout_hit) begin
                    state_d = DONE;
                    fail    = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        cnt_d = '0;
        if ((TIMEOUT_CYCLES != 0) && in_beat && !bus_ack_i && !timeout_hit)
            cnt_d = cnt_q + CW'(1);
    end

    // Load result is built from the next-cycle rdata so it is ready in DONE.
    always_comb begin
        raw = 32'({rdata1_d, rdata0_d} >> {off, 3'b000});
        case (cur.width[1:0])
            2'b00:   ld_ext = cur.width[2] ? {24'h0, raw[7:0]} : {{24{raw[7]}}, raw[7:0]};
            2'b11:   ld_ext = raw;
            default: ld_ext = cur.width[2] ? {16'h0, raw[15:0]} : {{16{raw[15]}}, raw[15:0]};
        endcase

        err_d     = (state_d == DONE) && fail;
        ld_data_d = ((state_d == DONE) && !fail && !cur.we) ? ld_ext : 32'h0;

        bus_req_d   = 1'b0;
        bus_we_d    = 1'b0;
        bus_addr_d  = 32'h0;
        bus_be_d    = 4'h0;
        bus_wdata_d = 32'h0;
        if (state_d == BEAT0) begin
            bus_req_d   = 1'b1;
            bus_we_d    = cur.we;
            bus_addr_d  = base_addr;
            bus_be_d    = be_wide[3:0];
            bus_wdata_d = wdata_lane[31:0];
        end else if (state_d == BEAT1) begin
            bus_req_d   = 1'b1;
            bus_we_d    = cur.we;
            bus_addr_d  = base_addr + 32'd4;
            bus_be_d    = be_wide[7:4];
            bus_wdata_d = wdata_lane[63:32];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            req_q       <= '0;
            rdata0_q    <= '0;
            rdata1_q    <= '0;
            cnt_q       <= '0;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_be_q    <= '0;
            bus_wdata_q <= '0;
            err_q       <= 1'b0;
            ld_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            req_q       <= req_d;
            rdata0_q    <= rdata0_d;
            rdata1_q    <= rdata1_d;
            cnt_q       <= cnt_d;
            bus_req_q   <= bus_req_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_be_q    <= bus_be_d;
            bus_wdata_q <= bus_wdata_d;
            err_q       <= err_d;
            ld_data_q   <= ld_data_d;
        end
    end

    assign stall_o     = ((state_q == IDLE) && req_i) || (state_q == BEAT0) || (state_q == BEAT1);
    assign done_o      = (state_q == DONE);
    assign err_o       = err_q;
    assign ld_data_o   = ld_data_q;
    assign bus_req_o   = bus_req_q;
    assign bus_we_o    = bus_we_q;
    assign bus_addr_o  = bus_addr_q;
    assign bus_be_o    = bus_be_q;
    assign bus_wdata_o = bus_wdata_q;

endmodule
